// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, fixed DATA_WIDTH+1 cycle latency, sign fix-up at the end.
module multdiv_iter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ctrl_MULT,
    input  logic                  ctrl_DIV,
    input  logic [DATA_WIDTH-1:0] data_operandA,
    input  logic [DATA_WIDTH-1:0] data_operandB,
    output logic [DATA_WIDTH-1:0] data_result,
    output logic                  data_exception,
    output logic                  data_resultRDY,
    output logic                  busy
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned PW    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               op_div_q, op_div_d;
    logic               sign_q, sign_d;
    logic [W-1:0]       a_mag_q, a_mag_d;
    logic [W-1:0]       b_mag_q, b_mag_d;
    logic [PW-1:0]      p_q, p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    logic               start;
    logic [W-1:0]       abs_a, abs_b;
    logic [W:0]         mul_sum;
    logic [PW-1:0]      mul_next;
    logic [W:0]         rem_shift;
    logic [W:0]         rem_sub;
    logic               div_ge;
    logic [W-1:0]       rem_new;
    logic [PW-1:0]      div_next;
    logic [PW-1:0]      prod_s;
    logic [W-1:0]       quo;
    logic [W-1:0]       quo_s;
    logic [W:0]         prod_top;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x);
        return x[W-1] ? W'(-x) : x;
    endfunction

    assign start = ctrl_MULT | ctrl_DIV;
    assign abs_a = magnitude(data_operandA);
    assign abs_b = magnitude(data_operandB);

    // Datapath: p_q holds {acc_hi, multiplier} for multiply, {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, p_q[PW-1:W]} + (p_q[0] ? {1'b0, a_mag_q} : (W+1)'(0));
        mul_next  = {mul_sum, p_q[W-1:1]};
        rem_shift = {p_q[PW-1:W], p_q[W-1]};
        div_ge    = rem_shift >= {1'b0, b_mag_q};
        rem_sub   = rem_shift - {1'b0, b_mag_q};
        rem_new   = div_ge ? W'(rem_sub) : W'(rem_shift);
        div_next  = {rem_new, p_q[W-2:0], div_ge};
        prod_s    = sign_q ? PW'(-p_q) : p_q;
        prod_top  = prod_s[PW-1:W-1];
        quo       = p_q[W-1:0];
        quo_s     = sign_q ? W'(-quo) : quo;
    end

    // Next-state and registered-output logic; a start pulse preempts everything else.
    always_comb begin
        state_d  = state_q;
        op_div_d = op_div_q;
        sign_d   = sign_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (start) begin
            state_d  = RUN;
            op_div_d = ~ctrl_MULT;
            sign_d   = data_operandA[W-1] ^ data_operandB[W-1];
            a_mag_d  = abs_a;
            b_mag_d  = abs_b;
            cnt_d    = '0;
            p_d      = {W'(0), ctrl_MULT ? abs_b : abs_a};
        end else begin
            case (state_q)
                RUN: begin
                    if (cnt_q < CNT_W'(W)) begin
                        p_d   = op_div_q ? div_next : mul_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = DONE;
                        rdy_d   = 1'b1;
                        if (op_div_q) begin
                            if (b_mag_q == '0) begin
                                result_d = '0;
                                exc_d    = 1'b1;
                            end else begin
                                result_d = quo_s;
                                // Only +2^(W-1) (most-negative / -1) is unrepresentable.
                                exc_d    = ~sign_q & quo[W-1];
                            end
                        end else begin
                            result_d = prod_s[W-1:0];
                            exc_d    = ~((&prod_top) | ~(|prod_top));
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_div_q <= 1'b0;
            sign_q   <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_div_q <= op_div_d;
            sign_q   <= sign_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule
